// File: rtl/nf10_pkt_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_INPUTS AXI4-Stream ports into one stream.
// A registered grant steers the winning input straight through; packets never interleave.
module nf10_pkt_rr_arbiter #(
    parameter int C_AXIS_DATA_WIDTH = 256,
    parameter int C_USER_WIDTH      = 128,
    parameter int NUM_INPUTS        = 5
) (
    input  logic                                     axi_aclk,
    input  logic                                     axi_resetn,
    input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [NUM_INPUTS*C_USER_WIDTH-1:0]       s_axis_tuser,
    input  logic [NUM_INPUTS-1:0]                    s_axis_tvalid,
    input  logic [NUM_INPUTS-1:0]                    s_axis_tlast,
    output logic [NUM_INPUTS-1:0]                    s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]           m_axis_tstrb,
    output logic [C_USER_WIDTH-1:0]                  m_axis_tuser,
    output logic                                     m_axis_tvalid,
    output logic                                     m_axis_tlast,
    input  logic                                     m_axis_tready
);

    localparam int GW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_ptr;
    logic [GW-1:0] winner;
    logic [GW-1:0] idx;
    logic          found;
    logic          sending;

    logic [NUM_INPUTS-1:0][C_AXIS_DATA_WIDTH-1:0] tdata_a;
    logic [NUM_INPUTS-1:0][SW-1:0]                tstrb_a;
    logic [NUM_INPUTS-1:0][C_USER_WIDTH-1:0]      tuser_a;

    assign tdata_a = s_axis_tdata;
    assign tstrb_a = s_axis_tstrb;
    assign tuser_a = s_axis_tuser;
    assign sending = (state == SEND);

    // Rotating priority: the input just after last_ptr is looked at first.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            idx = GW'((int'(last_ptr) + k) % NUM_INPUTS);
            if (!found && s_axis_tvalid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign m_axis_tdata  = tdata_a[grant];
    assign m_axis_tstrb  = tstrb_a[grant];
    assign m_axis_tuser  = tuser_a[grant];
    assign m_axis_tvalid = sending && s_axis_tvalid[grant];
    assign m_axis_tlast  = sending && s_axis_tlast[grant];

    genvar i;
    generate
        for (i = 0; i < NUM_INPUTS; i++) begin : g_rdy
            assign s_axis_tready[i] = sending && (grant == GW'(i)) && m_axis_tready;
        end
    endgenerate

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state    <= IDLE;
            grant    <= '0;
            last_ptr <= GW'(NUM_INPUTS - 1);
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant <= winner;
                    state <= SEND;
                end
                SEND: if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state    <= IDLE;
                    last_ptr <= grant;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nf10_pkt_rr_arbiter.sv
// Directed bench for the packet round-robin arbiter; tuser carries the source index
// so every output beat identifies which input it came from.
module tb_nf10_pkt_rr_arbiter;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int UW = 8;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*DW-1:0] s_tdata;
    logic [N*SW-1:0] s_tstrb;
    logic [N*UW-1:0] s_tuser;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]   m_tdata;
    logic [SW-1:0]   m_tstrb;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid, m_tlast, m_tready;

    logic [DW-1:0]   d [N];
    logic [N-1:0]    vin, lin;
    int vectors = 0;
    int miscompares = 0;

    nf10_pkt_rr_arbiter #(.C_AXIS_DATA_WIDTH(DW), .C_USER_WIDTH(UW), .NUM_INPUTS(N)) dut (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready)
    );

    always_comb begin
        s_tdata = '0;
        s_tstrb = '0;
        s_tuser = '0;
        for (int i = 0; i < N; i++) begin
            s_tdata[i*DW +: DW] = d[i];
            s_tstrb[i*SW +: SW] = d[i][SW-1:0];
            s_tuser[i*UW +: UW] = {4'(i), d[i][3:0]};
        end
    end
    assign s_tvalid = vin;
    assign s_tlast  = lin;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic v, input logic [DW-1:0] dat, input logic l);
        vin[i] = v;
        d[i]   = dat;
        lin[i] = l;
    endtask

    task automatic idle_chk(input string tag);
        #1;
        chk({tag, ".vld"}, 64'(m_tvalid), 64'd0);
        chk({tag, ".last"}, 64'(m_tlast), 64'd0);
        chk({tag, ".rdy"}, 64'(s_tready), 64'd0);
    endtask

    task automatic beat_chk(input string tag, input int src, input logic [DW-1:0] dat,
                            input logic l, input logic rdy);
        logic [N-1:0] one;
        one = 1;
        #1;
        chk({tag, ".vld"}, 64'(m_tvalid), 64'd1);
        chk({tag, ".data"}, 64'(m_tdata), 64'(dat));
        chk({tag, ".user"}, 64'(m_tuser), 64'({4'(src), dat[3:0]}));
        chk({tag, ".strb"}, 64'(m_tstrb), 64'(dat[SW-1:0]));
        chk({tag, ".last"}, 64'(m_tlast), 64'(l));
        chk({tag, ".rdy"}, 64'(s_tready), rdy ? 64'(one << src) : 64'd0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        vin = '0;
        lin = '0;
        m_tready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $fatal(1, "FAIL watchdog: bench did not finish");
    end

    initial begin
        int order [6];
        order = '{0, 1, 2, 3, 4, 0};
        vin = '0;
        lin = '0;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) d[i] = '0;

        // Reset state
        tick();
        idle_chk("rst");
        tick();
        rst_n = 1'b1;

        // Input 2 sends a 3-beat packet
        put(2, 1, 16'h00A0, 0);
        idle_chk("t1.arb");
        tick(); beat_chk("t1.b0", 2, 16'h00A0, 0, 1);
        tick(); put(2, 1, 16'h00A1, 0); beat_chk("t1.b1", 2, 16'h00A1, 0, 1);
        tick(); put(2, 1, 16'h00A2, 1); beat_chk("t1.b2", 2, 16'h00A2, 1, 1);
        tick(); put(2, 0, 16'h0000, 0); idle_chk("t1.end");

        // All inputs continuously valid with 2-beat packets
        reset_pulse();
        for (int i = 0; i < N; i++) put(i, 1, 16'(i * 16), 0);
        for (int p = 0; p < 6; p++) begin
            idle_chk("t2.gap");
            tick(); beat_chk("t2.b0", order[p], 16'(order[p] * 16), 0, 1);
            tick(); put(order[p], 1, 16'(order[p] * 16 + 1), 1);
            beat_chk("t2.b1", order[p], 16'(order[p] * 16 + 1), 1, 1);
            tick(); put(order[p], 1, 16'(order[p] * 16), 0);
        end

        // Mid-packet bubble on input 1 while input 3 waits
        reset_pulse();
        put(1, 1, 16'h0010, 0);
        put(3, 1, 16'h0030, 1);
        idle_chk("t3.arb");
        tick(); beat_chk("t3.b0", 1, 16'h0010, 0, 1);
        tick(); put(1, 0, 16'h0010, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3.bub.vld", 64'(m_tvalid), 64'd0);
            chk("t3.bub.rdy", 64'(s_tready), 64'h02);
            tick();
        end
        put(1, 1, 16'h0011, 1);
        beat_chk("t3.b1", 1, 16'h0011, 1, 1);
        tick(); put(1, 0, 16'h0000, 0); idle_chk("t3.gap");
        tick(); beat_chk("t3.i3", 3, 16'h0030, 1, 1);
        tick(); put(3, 0, 16'h0000, 0); idle_chk("t3.end");

        // Backpressure during a 4-beat packet from input 0
        reset_pulse();
        put(0, 1, 16'h00B0, 0);
        idle_chk("t4.arb");
        tick(); beat_chk("t4.b0", 0, 16'h00B0, 0, 1);
        tick(); put(0, 1, 16'h00B1, 0); m_tready = 1'b0;
        beat_chk("t4.stall1", 0, 16'h00B1, 0, 0);
        tick(); beat_chk("t4.stall2", 0, 16'h00B1, 0, 0);
        tick(); m_tready = 1'b1; beat_chk("t4.b1", 0, 16'h00B1, 0, 1);
        tick(); put(0, 1, 16'h00B2, 0); beat_chk("t4.b2", 0, 16'h00B2, 0, 1);
        tick(); put(0, 1, 16'h00B3, 1); beat_chk("t4.b3", 0, 16'h00B3, 1, 1);
        tick(); put(0, 0, 16'h0000, 0); idle_chk("t4.end");

        // Inputs 0 and 4 with last_ptr=4: 0 first, then 4 despite 0 re-requesting
        reset_pulse();
        put(0, 1, 16'h00C0, 1);
        put(4, 1, 16'h0040, 1);
        idle_chk("t5.arb");
        tick(); beat_chk("t5.i0", 0, 16'h00C0, 1, 1);
        tick(); put(0, 1, 16'h00C1, 1); idle_chk("t5.gap");
        tick(); beat_chk("t5.i4", 4, 16'h0040, 1, 1);
        tick(); put(4, 0, 16'h0000, 0); put(0, 0, 16'h0000, 0);

        // Asynchronous reset in beat 2 of a packet from input 2
        reset_pulse();
        put(2, 1, 16'h00D0, 0);
        idle_chk("t6.arb");
        tick(); beat_chk("t6.b0", 2, 16'h00D0, 0, 1);
        tick(); put(2, 1, 16'h00D1, 0); beat_chk("t6.b1", 2, 16'h00D1, 0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6.async.vld", 64'(m_tvalid), 64'd0);
        chk("t6.async.rdy", 64'(s_tready), 64'd0);
        put(0, 1, 16'h00E0, 1);
        tick(); rst_n = 1'b1; idle_chk("t6.rel");
        tick(); beat_chk("t6.pri", 0, 16'h00E0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nf10_pkt_rr_arbiter.md
Name: nf10_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_INPUTS AXI4-Stream ingress ports into a single stream.
- Sits upstream of the output-port lookup and the BRAM output queues.
- Once a packet starts it owns the output until its tlast beat; packets are never interleaved.
- No data buffering: a registered grant steers the selected input straight through to the output.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width per stream.
- C_USER_WIDTH, 128, tuser width per stream.
- NUM_INPUTS, 5, number of slave streams (≥1); grant index width = max(1, ceil(log2(NUM_INPUTS))).

Ports:
- axi_aclk  in  1  single clock for the whole block.
- axi_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_INPUTS*C_AXIS_DATA_WIDTH  input i occupies slice [i*W +: W].
- s_axis_tstrb  in  NUM_INPUTS*C_AXIS_DATA_WIDTH/8  same slicing rule.
- s_axis_tuser  in  NUM_INPUTS*C_USER_WIDTH  same slicing rule.
- s_axis_tvalid  in  NUM_INPUTS  one bit per input.
- s_axis_tlast  in  NUM_INPUTS  one bit per input.
- s_axis_tready  out  NUM_INPUTS  one bit per input.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged stream.
- m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  merged stream.
- m_axis_tuser  out  C_USER_WIDTH  merged stream.
- m_axis_tvalid  out  1  merged stream valid.
- m_axis_tlast  out  1  merged stream last.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset: reset is asynchronous on assertion. It forces state=IDLE, grant=0, last_ptr=NUM_INPUTS-1, so input 0 has first priority.
- Outputs while in reset or IDLE: m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=all 0. m_axis_tdata/tstrb/tuser are don't-care.
- Registers:
  - state (IDLE, SEND).
  - grant: index of the owning input.
  - last_ptr: index of the last input granted.
- IDLE:
  - Scan inputs in rotation order last_ptr+1, last_ptr+2, …, last_ptr, modulo NUM_INPUTS.
  - The first input with s_axis_tvalid=1 wins. Next clock: grant<=winner, state<=SEND.
  - If no tvalid is high, remain in IDLE.
  - Arbitration costs exactly one idle cycle per packet.
- SEND:
  - m_axis_tdata/tstrb/tuser/tlast/tvalid are driven combinationally from input[grant].
  - s_axis_tready[grant]=m_axis_tready; every other s_axis_tready bit is 0.
- Transfer: a beat transfers when m_axis_tvalid & m_axis_tready.
- End of packet: when a beat transfers with tlast=1, then next clock state<=IDLE and last_ptr<=grant.
- Packet atomicity:
  - A bubble on the granted input (tvalid low mid-packet) holds the grant; m_axis_tvalid drops with it.
  - Other inputs are never served until tlast transfers. There is no timeout.
- Backpressure: m_axis_tready low holds everything. The granted input sees tready low and must keep its data stable (AXI rule).
- Single-beat packet (tlast on first beat): SEND lasts one transfer cycle, then IDLE.
- Fairness: with all inputs continuously valid, the grant sequence is 0,1,…,N-1,0,…. Any requesting input waits at most NUM_INPUTS-1 packets.
- Simultaneous events: tvalid changes on non-granted inputs during SEND have no effect. An input whose own tvalid falls while in IDLE simply loses that scan cycle.
- NUM_INPUTS=1: degenerates to pass-through with one idle cycle between packets.
- Reset mid-packet:
  - The partial packet is abandoned and the output is immediately invalid.
  - Downstream sees a truncated packet with no tlast. This is acceptable; system reset is global.
- Latency:
  - Zero cycles data-path (combinational mux).
  - One cycle from first tvalid in IDLE to m_axis_tvalid.

Test Plan:
- Reset then input 2 sends a 3-beat packet (tdata 0xA0,0xA1,0xA2; tlast on beat 3), m_tready=1 → m_tvalid rises 1 cycle after s_tvalid[2]; output beats 0xA0..0xA2 with tlast on 0xA2; s_tready[2] high exactly 3 transfer cycles; other tready always 0.
- All 5 inputs hold 2-beat packets continuously → output source order 0,1,2,3,4,0; one idle cycle between packets; no interleaving.
- Input 1 mid-packet deasserts tvalid for 4 cycles while input 3 is valid → m_tvalid low 4 cycles, grant stays on 1; input 3 served only after input 1's tlast.
- m_tready toggles 1,0,0,1 during a 4-beat packet from input 0 → tdata/tuser stable while stalled; s_tready[0] mirrors m_tready; 4 beats transfer intact.
- Inputs 0 and 4 valid with last_ptr=4 → input 0 wins; after its packet, input 4 wins even though input 0 immediately re-requests.
- Assert axi_resetn low asynchronously in beat 2 of a packet from input 2 → m_tvalid and s_tready drop without waiting for a clock edge; after release, input 0 has priority over a simultaneous request from input 2.
